// File: rtl/bp_update_scheduler_pkg.sv
// bp_update_scheduler_pkg: resolve packet, scheduler state and default table init value
`ifndef N
`define N 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LOCAL_PREDICTOR_BITS
`define LOCAL_PREDICTOR_BITS 4
`endif
package bp_update_scheduler_pkg;
  typedef struct packed {
    logic              valid;
    logic [`XLEN-1:0]  pc;
    logic              taken;
  } BRANCH_PREDICTION_PACKET;
  typedef enum logic {INIT, RUN} bp_state_e;
  localparam logic [1:0] INIT_VALUE_DEFAULT = 2'd2;
  localparam int PORTS = `N;
endpackage

// File: rtl/bp_resolve_fifo.sv
// bp_resolve_fifo: PORTS-wide compacting enqueue, single dequeue, registered occupancy
module bp_resolve_fifo #(
  parameter int DEPTH = 8,
  parameter int IW    = 4,
  parameter int PORTS = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [PORTS-1:0] enq_valid,
  input  logic [IW-1:0]    enq_idx [PORTS],
  input  logic [PORTS-1:0] enq_taken,
  input  logic             deq,
  output logic [IW-1:0]    head_idx,
  output logic             head_taken,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [IW:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd, w_num;
  logic [AW:0] w_slot [PORTS];
  // each valid port lands right after the valid ports below it, so no holes
  always_comb begin
    w_num = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_slot[p] = r_wr + w_num;
      w_num = w_num + (AW+1)'(enq_valid[p]);
    end
  end
  always_ff @(posedge clock)
    for (int p = 0; p < PORTS; p++)
      if (enq_valid[p]) r_mem[w_slot[p][AW-1:0]] <= {enq_idx[p], enq_taken[p]};
  always_ff @(posedge clock)
    if (reset || flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      count <= '0;
    end else begin
      r_wr  <= r_wr + w_num;
      r_rd  <= r_rd + (AW+1)'(deq);
      count <= count + w_num - (AW+1)'(deq);
    end
  assign empty = r_wr == r_rd;
  assign {head_idx, head_taken} = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: init sweep then queued saturating-counter updates of the predictor table.
// BP_UPDATE_BYPASS_EN: write the lowest-port resolve straight through when the queue is empty.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int         TABLE_BITS = `LOCAL_PREDICTOR_BITS,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [1:0] INIT_VALUE = INIT_VALUE_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init_req,
  input  BRANCH_PREDICTION_PACKET branch_prediction_resolves [PORTS],
  output logic                    resolve_ready,
  output logic                    tbl_wr_en,
  output logic                    tbl_wr_init,
  output logic [TABLE_BITS-1:0]   tbl_wr_idx,
  output logic                    tbl_wr_taken,
  output logic [1:0]              tbl_wr_value,
  output logic                    init_busy,
  output logic                    overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  bp_state_e             r_state;
  logic [TABLE_BITS-1:0] r_sweep;
  logic                  r_overflow;
  logic [PORTS-1:0]      w_valid, w_taken, w_enq;
  logic [TABLE_BITS-1:0] w_idx [PORTS];
  logic [TABLE_BITS-1:0] w_head_idx, w_byp_idx;
  logic [AW:0]           w_count;
  logic w_empty, w_run, w_accept, w_deq, w_byp, w_head_taken, w_byp_taken, w_unused_pc;
  always_comb begin
    w_unused_pc = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      w_valid[p]  = branch_prediction_resolves[p].valid;
      w_taken[p]  = branch_prediction_resolves[p].taken;
      w_idx[p]    = branch_prediction_resolves[p].pc[TABLE_BITS+1:2];
      w_unused_pc = w_unused_pc ^ (^branch_prediction_resolves[p].pc);
    end
  end
  assign w_run = r_state == RUN;
  assign resolve_ready = w_run && (((AW+1)'(FIFO_DEPTH) - w_count) >= (AW+1)'(PORTS));
  assign w_accept = resolve_ready && !init_req;
`ifdef BP_UPDATE_BYPASS_EN
  always_comb begin
    w_byp = w_accept && w_empty && |w_valid;
    w_byp_idx = '0;
    w_byp_taken = 1'b0;
    for (int p = PORTS-1; p >= 0; p--)
      if (w_valid[p]) begin
        w_byp_idx = w_idx[p];
        w_byp_taken = w_taken[p];
      end
    w_enq = !w_accept ? '0 : w_byp ? (w_valid & (w_valid - PORTS'(1))) : w_valid;
  end
`else
  always_comb begin
    w_byp = 1'b0;
    w_byp_idx = '0;
    w_byp_taken = 1'b0;
    w_enq = w_accept ? w_valid : '0;
  end
`endif
  // an init request pre-empts the head so nothing non-init is written once a flush is asked for
  assign w_deq = w_run && !init_req && !w_empty;
  always_comb begin
    init_busy    = !w_run;
    tbl_wr_init  = !w_run;
    tbl_wr_en    = !w_run || w_byp || w_deq;
    tbl_wr_idx   = !w_run ? r_sweep : w_byp ? w_byp_idx : w_head_idx;
    tbl_wr_taken = w_byp ? w_byp_taken : w_head_taken;
    tbl_wr_value = INIT_VALUE;
    overflow     = r_overflow;
  end
  always_ff @(posedge clock)
    if (reset) begin
      r_state    <= INIT;
      r_sweep    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (|w_valid && !resolve_ready) r_overflow <= 1'b1;
      if (init_req) begin
        r_state <= INIT;
        r_sweep <= '0;
      end else if (!w_run) begin
        r_sweep <= r_sweep + TABLE_BITS'(1);
        r_state <= &r_sweep ? RUN : INIT;
      end
    end
  bp_resolve_fifo #(.DEPTH(FIFO_DEPTH), .IW(TABLE_BITS), .PORTS(PORTS)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (init_req),
    .enq_valid  (w_enq),
    .enq_idx    (w_idx),
    .enq_taken  (w_taken),
    .deq        (w_deq),
    .head_idx   (w_head_idx),
    .head_taken (w_head_taken),
    .empty      (w_empty),
    .count      (w_count)
  );
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: directed checks of init sweep, queued updates, drops and flushes
module tb_bp_update_scheduler;
  import bp_update_scheduler_pkg::*;
`ifdef BP_UPDATE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, init_req = 1'b0;
  BRANCH_PREDICTION_PACKET bpr [2];
  logic resolve_ready, tbl_wr_en, tbl_wr_init, tbl_wr_taken, init_busy, overflow;
  logic [3:0] tbl_wr_idx;
  logic [1:0] tbl_wr_value;
  int total = 0, bad = 0;
  logic [4:0] q [$];
  logic exp_ovf = 1'b0;
  always #5 clock = ~clock;
  bp_update_scheduler #(.TABLE_BITS(4), .FIFO_DEPTH(8)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .init_req                   (init_req),
    .branch_prediction_resolves (bpr),
    .resolve_ready              (resolve_ready),
    .tbl_wr_en                  (tbl_wr_en),
    .tbl_wr_init                (tbl_wr_init),
    .tbl_wr_idx                 (tbl_wr_idx),
    .tbl_wr_taken               (tbl_wr_taken),
    .tbl_wr_value               (tbl_wr_value),
    .init_busy                  (init_busy),
    .overflow                   (overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [31:0] pc0, input logic t0,
                       input logic v1, input logic [31:0] pc1, input logic t1);
    bpr[0].valid = v0; bpr[0].pc = pc0; bpr[0].taken = t0;
    bpr[1].valid = v1; bpr[1].pc = pc1; bpr[1].taken = t1;
  endtask
  task automatic mcycle(input logic v0, input logic [31:0] pc0, input logic t0,
                        input logic v1, input logic [31:0] pc1, input logic t1);
    bit rdy, byp, en;
    logic [4:0] wr;
    drive(v0, pc0, t0, v1, pc1, t1);
    #1;
    rdy = (8 - q.size()) >= 2;
    byp = BYP && rdy && q.size() == 0 && (v0 || v1);
    en  = byp || q.size() > 0;
    chk("ready", resolve_ready, rdy);
    chk("overflow", overflow, exp_ovf);
    chk("wr_en", tbl_wr_en, en);
    if (en) begin
      wr = byp ? (v0 ? {pc0[5:2], t0} : {pc1[5:2], t1}) : q[0];
      chk("wr_idx", tbl_wr_idx, wr[4:1]);
      chk("wr_taken", tbl_wr_taken, wr[0]);
      chk("wr_init", tbl_wr_init, 0);
    end
    if (!byp && q.size() > 0) void'(q.pop_front());
    if (rdy) begin
      if (v0 && !byp) q.push_back({pc0[5:2], t0});
      if (v1 && !(byp && !v0)) q.push_back({pc1[5:2], t1});
    end else if (v0 || v1) exp_ovf = 1'b1;
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_idx", tbl_wr_idx, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_ready", resolve_ready, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sweep_en", tbl_wr_en, 1);
      chk("sweep_init", tbl_wr_init, 1);
      chk("sweep_idx", tbl_wr_idx, i);
      chk("sweep_busy", init_busy, 1);
      chk("sweep_ready", resolve_ready, 0);
      tick();
    end
    chk("run_busy", init_busy, 0);
    chk("run_ready", resolve_ready, 1);
    chk("run_idle_en", tbl_wr_en, 0);
    chk("init_value", tbl_wr_value, 2);
`ifdef BP_UPDATE_BYPASS_EN
    drive(0, 0, 0, 1, 32'h3C, 1);
    #1;
    chk("byp_en", tbl_wr_en, 1);
    chk("byp_idx", tbl_wr_idx, 15);
    chk("byp_taken", tbl_wr_taken, 1);
    chk("byp_init", tbl_wr_init, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp_empty_en", tbl_wr_en, 0);
    chk("byp_empty_ready", resolve_ready, 1);
    tick();
`else
    drive(1, 32'h24, 1, 1, 32'h08, 0);
    #1;
    chk("lat_t0_en", tbl_wr_en, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("lat_t1_en", tbl_wr_en, 1);
    chk("lat_t1_idx", tbl_wr_idx, 9);
    chk("lat_t1_taken", tbl_wr_taken, 1);
    chk("lat_t1_init", tbl_wr_init, 0);
    tick();
    chk("lat_t2_en", tbl_wr_en, 1);
    chk("lat_t2_idx", tbl_wr_idx, 2);
    chk("lat_t2_taken", tbl_wr_taken, 0);
    tick();
    chk("lat_t3_en", tbl_wr_en, 0);
`endif
    for (int k = 0; k < 8; k++)
      mcycle(1, 32'hABC0_0000 | 32'((2 * k) << 2), k[0], 1, 32'h0000_1000 | 32'((2 * k + 1) << 2), !k[0]);
    chk("burst_ovf", overflow, 1);
    for (int i = 0; i < 12 && q.size() > 0; i++) mcycle(0, 0, 0, 0, 0, 0);
    mcycle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      mcycle(1, 32'((k + 3) << 2), 1, 1, 32'((k + 8) << 2), 0);
    init_req = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    init_req = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      chk("flush_en", tbl_wr_en, 1);
      chk("flush_init", tbl_wr_init, 1);
      chk("flush_idx", tbl_wr_idx, i);
      chk("flush_ovf", overflow, 1);
      tick();
    end
    chk("flush_done_en", tbl_wr_en, 0);
    chk("flush_done_ready", resolve_ready, 1);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("restart_idx", tbl_wr_idx, i);
      tick();
    end
    chk("restart_idx3", tbl_wr_idx, 3);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("restart_from0", tbl_wr_idx, 0);
    tick();
    chk("restart_idx1", tbl_wr_idx, 1);
    drive(1, 32'h24, 1, 0, 0, 0);
    #1;
    chk("init_drop_ready", resolve_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("init_drop_ovf", overflow, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_idx7", tbl_wr_idx, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rerst_idx", tbl_wr_idx, 0);
    chk("rerst_init", tbl_wr_init, 1);
    chk("rerst_en", tbl_wr_en, 1);
    chk("rerst_ovf", overflow, 0);
    tick();
    chk("rerst_idx1", tbl_wr_idx, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_update_scheduler.md
BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

Interface
- REQ-001 SHALL have parameter TABLE_BITS, default `LOCAL_PREDICTOR_BITS: predictor index width; table has 2**TABLE_BITS entries.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 8: resolve-queue entries; power of two, >= 2*`N.
- REQ-003 SHALL have parameter INIT_VALUE, default 2'd2: counter value written during the init sweep.
- REQ-004 clock  input  1  sole clock; all state updates on posedge.
- REQ-005 reset  input  1  synchronous, active-high.
- REQ-006 init_req  input  1  restart the table init sweep; pulse.
- REQ-007 branch_prediction_resolves  input  BRANCH_PREDICTION_PACKET[`N]  per-port valid/pc/taken resolves.
- REQ-008 resolve_ready  output  1  queue can accept `N packets this cycle.
- REQ-009 tbl_wr_en  output  1  table write strobe.
- REQ-010 tbl_wr_init  output  1  1: write INIT_VALUE absolute; 0: saturating increment/decrement.
- REQ-011 tbl_wr_idx  output  TABLE_BITS  table index.
- REQ-012 tbl_wr_taken  output  1  direction for non-init writes.
- REQ-013 init_busy  output  1  init sweep in progress.
- REQ-014 overflow  output  1  sticky: a valid packet was dropped.

Function
- REQ-015 States: INIT, RUN. INIT: one write per cycle, tbl_wr_en=1, tbl_wr_init=1, tbl_wr_idx = sweep counter 0..2**TABLE_BITS-1; after the last index, go to RUN next cycle.
- REQ-016 init_busy = (state==INIT); resolve_ready = 0 in INIT; valid packets arriving in INIT are dropped and set overflow.
- REQ-017 RUN: valid packets are enqueued in ascending port order, compacted (no holes), index = pc[TABLE_BITS+1:2], with the taken bit.
- REQ-018 resolve_ready = (state==RUN) && free slots >= `N, computed from registered occupancy only.
- REQ-019 Valid packets presented while resolve_ready=0 are dropped; each drop sets overflow, which stays 1 until reset.
- REQ-020 RUN: when the queue is non-empty, the head is popped and driven as tbl_wr_en=1, tbl_wr_init=0, idx/taken = head; at most one write per cycle.
- REQ-021 Latency, enqueue to write: 1 cycle minimum; strict FIFO order across cycles and ports.
- REQ-022 Simultaneous enqueue and dequeue in one cycle SHALL be supported at any occupancy, including full minus `N.
- REQ-023 Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full and empty are told apart by the MSB.
- REQ-024 init_req in any state: the queue is flushed (entries discarded, not counted as overflow), the sweep counter goes to 0, and the state goes to INIT next cycle. init_req during INIT restarts the sweep from 0.
- REQ-025 tbl_wr_en=0 whenever RUN and the queue is empty. tbl_wr_idx/tbl_wr_taken are don't-care when tbl_wr_en=0.

Reset
- REQ-026 Reset SHALL force state=INIT, sweep counter=0, pointers=0, overflow=0.
- REQ-027 Cycle after reset deassertion: tbl_wr_en=1, tbl_wr_init=1, tbl_wr_idx=0, init_busy=1, resolve_ready=0.
- REQ-028 Reset asserted mid-sweep or mid-drain SHALL discard all queued packets and restart at index 0.

Configuration
- REQ-029 BP_UPDATE_BYPASS_EN defined: in RUN with the queue empty, the lowest-port valid packet is written in the same cycle (combinational, zero latency) and the remaining valid packets are enqueued. Not defined: every packet passes through the queue (REQ-021 latency).

Structure
- REQ-030 BRANCH_PREDICTION_PACKET, the state enum, and the INIT_VALUE default SHALL live in the shared package. `N and `XLEN come from the shared defines.
- REQ-031 The queue SHALL be a sub-module bp_resolve_fifo: `N-wide compacting enqueue, single dequeue, registered count.

Verification (TABLE_BITS=4, FIFO_DEPTH=8, `N=2)
- REQ-032 Release reset -> idx 0..15 written with init=1 on 16 consecutive cycles, then init_busy=0 and resolve_ready=1.
- REQ-033 Cycle t in RUN: port0 pc=0x24 taken=1, port1 pc=0x08 taken=0 -> t+1 write idx 9 taken=1, t+2 write idx 2 taken=0 (non-bypass build).
- REQ-034 Present 2 valid packets every cycle for 8 cycles -> resolve_ready falls once occupancy >6. Packets held with ready=0 set overflow=1, and the written sequence matches accepted packets in order.
- REQ-035 init_req with 5 entries queued -> no further non-init writes, sweep restarts at idx 0, overflow unchanged.
- REQ-036 BP_UPDATE_BYPASS_EN build, queue empty: port1 pc=0x3C taken=1 only -> write idx 15 in the same cycle, queue stays empty.
- REQ-037 Reset at sweep idx 7 -> the next write is idx 0 with init=1, and overflow=0.
